// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - shared types and defaults for the run sequencer
package run_seq_pkg;

    localparam int NUM_PROGS_DEF    = 3;
    localparam int START_CYCLES_DEF = 2;
    localparam int CW_DEF           = 16;
    localparam int TIMEOUT_DEF      = 4000;

    // Index width with a floor of one bit so single-entry counts stay legal
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PW_DEF = idx_width(NUM_PROGS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT_START,
        RUN,
        REPORT,
        FINISHED
    } seq_state_t;

    // One per-program result as seen by the host, at default widths
    typedef struct packed {
        logic [PW_DEF-1:0] prog;
        logic [CW_DEF-1:0] cycles;
        logic              timeout;
    } rpt_t;

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - RUN-cycle counter with watchdog terminal compare
module run_cycle_counter #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    // Count enabled cycles; clear wins so every run starts from zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT);

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - runs NUM_PROGS core programs back to back and reports cycle counts
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter  int NUM_PROGS    = NUM_PROGS_DEF,
    parameter  int START_CYCLES = START_CYCLES_DEF,
    parameter  int CW           = CW_DEF,
    parameter  int TIMEOUT      = TIMEOUT_DEF,
    localparam int PW           = idx_width(NUM_PROGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          abort,
    output logic          core_start,
    input  logic          core_done,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic [PW-1:0] rpt_prog,
    output logic [CW-1:0] rpt_cycles,
    output logic          rpt_timeout,
    output logic          busy,
    output logic          all_done
);

    localparam int SW = idx_width(START_CYCLES);
    localparam logic [PW-1:0] LAST_PROG  = PW'(NUM_PROGS - 1);
    localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_V  = CW'(TIMEOUT);

    seq_state_t    state;
    logic [PW-1:0] prog_idx;
    logic [SW-1:0] start_cnt;
    logic [CW-1:0] cycle_cnt;
    logic          at_limit;
    logic          cnt_clear;
    logic          cnt_enable;

    // The counter only advances while the core is running and nothing ends the run
    assign cnt_clear  = (state != RUN);
    assign cnt_enable = (state == RUN) && !core_done && !at_limit;

    run_cycle_counter #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cycle_cnt),
        .at_limit (at_limit)
    );

    // Sequencing FSM: start pulse, timed run, report handshake, next program
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state       <= IDLE;
            prog_idx    <= '0;
            start_cnt   <= '0;
            rpt_prog    <= '0;
            rpt_cycles  <= '0;
            rpt_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISHED: begin
                    if (go) begin
                        state     <= ASSERT_START;
                        prog_idx  <= '0;
                        start_cnt <= '0;
                    end
                end
                ASSERT_START: begin
                    if (start_cnt == START_LAST) begin
                        state <= RUN;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // done beats the watchdog when both land on the same cycle
                    if (core_done) begin
                        state       <= REPORT;
                        rpt_prog    <= prog_idx;
                        rpt_cycles  <= cycle_cnt;
                        rpt_timeout <= 1'b0;
                    end else if (at_limit) begin
                        state       <= REPORT;
                        rpt_prog    <= prog_idx;
                        rpt_cycles  <= TIMEOUT_V;
                        rpt_timeout <= 1'b1;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        if (prog_idx == LAST_PROG) begin
                            state <= FINISHED;
                        end else begin
                            state     <= ASSERT_START;
                            prog_idx  <= prog_idx + 1'b1;
                            start_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register
    assign core_start = (state != RUN);
    assign rpt_valid  = (state == REPORT);
    assign busy       = (state == ASSERT_START) || (state == RUN) || (state == REPORT);
    assign all_done   = (state == FINISHED);

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized self-checking bench for run_sequencer
module tb_run_sequencer;
    import run_seq_pkg::*;

    localparam int NP    = 3;
    localparam int SC    = 2;
    localparam int TO    = 20;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset, go, abort, core_start, core_done;
    logic        rpt_valid, rpt_ready, rpt_timeout, busy, all_done;
    logic [1:0]  rpt_prog;
    logic [15:0] rpt_cycles;

    always #5 clk = ~clk;

    run_sequencer #(
        .NUM_PROGS    (NP),
        .START_CYCLES (SC),
        .CW           (16),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .abort       (abort),
        .core_start  (core_start),
        .core_done   (core_done),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_prog    (rpt_prog),
        .rpt_cycles  (rpt_cycles),
        .rpt_timeout (rpt_timeout),
        .busy        (busy),
        .all_done    (all_done)
    );

    int   tests = 0;
    int   fails = 0;
    int   delay_a[NP];
    int   wait_a[NP];
    rpt_t exp_q[$];
    int   run_prog, run_idx, hi_cnt, stall_left, n_acc, busy_cnt, exp_busy;
    bit   prev_low, prev_valid, acc_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_core_start", 32'(core_start), 1);
        chk("rst_rpt_valid", 32'(rpt_valid), 0);
        chk("rst_rpt_prog", 32'(rpt_prog), 0);
        chk("rst_rpt_cycles", 32'(rpt_cycles), 0);
        chk("rst_rpt_timeout", 32'(rpt_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_all_done", 32'(all_done), 0);
    endtask

    // One clock: sample after the edge, check, then drive the core and host models
    task automatic step();
        @(posedge clk);
        #1;
        if (acc_prev) chk("valid_falls_after_accept", 32'(rpt_valid), 0);
        acc_prev = 1'b0;
        if (busy) busy_cnt++;
        if (!core_start) begin
            if (!prev_low) begin
                chk("start_high_cycles", hi_cnt, SC);
                run_prog++;
                run_idx = 0;
            end else begin
                run_idx++;
            end
            hi_cnt    = 0;
            core_done = (run_prog >= 0 && run_prog < NP) ? (run_idx == delay_a[run_prog]) : 1'b0;
        end else begin
            if (busy && !rpt_valid) hi_cnt++;
            else hi_cnt = 0;
            core_done = 1'($urandom_range(0, 1));
        end
        prev_low = !core_start;
        if (rpt_valid) begin
            if (!prev_valid) stall_left = (n_acc < NP) ? wait_a[n_acc] : 0;
            chk("report_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("rpt_prog", 32'(rpt_prog), 32'(exp_q[0].prog));
                chk("rpt_cycles", 32'(rpt_cycles), 32'(exp_q[0].cycles));
                chk("rpt_timeout", 32'(rpt_timeout), 32'(exp_q[0].timeout));
            end
            if (stall_left > 0) begin
                rpt_ready = 1'b0;
                stall_left--;
            end else begin
                rpt_ready = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_acc++;
                acc_prev = 1'b1;
            end
        end else begin
            rpt_ready = 1'($urandom_range(0, 1));
        end
        prev_valid = rpt_valid;
        go = busy ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    // Build the expected report list from the delays and launch with a go pulse
    task automatic start_seq(input int d0, d1, d2, w0, w1, w2);
        delay_a = '{d0, d1, d2};
        wait_a  = '{w0, w1, w2};
        exp_q.delete();
        exp_busy = 0;
        for (int p = 0; p < NP; p++) begin
            if (delay_a[p] < TO) begin
                exp_q.push_back('{prog: 2'(p), cycles: 16'(delay_a[p]), timeout: 1'b0});
                exp_busy += SC + delay_a[p] + 1 + 1 + wait_a[p];
            end else begin
                exp_q.push_back('{prog: 2'(p), cycles: 16'(TO), timeout: 1'b1});
                exp_busy += SC + TO + 1 + wait_a[p];
            end
        end
        run_prog   = -1;
        n_acc      = 0;
        busy_cnt   = 0;
        prev_valid = 1'b0;
        acc_prev   = 1'b0;
        go         = 1'b1;
        step();
    endtask

    task automatic finish_seq();
        int guard = 0;
        while (!all_done && guard < 3000) begin
            step();
            guard++;
        end
        chk("seq_completes", 32'(all_done), 1);
        chk("reports_accepted", n_acc, NP);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("finished_valid_low", 32'(rpt_valid), 0);
        chk("finished_core_parked", 32'(core_start), 1);
        chk("finished_last_prog", 32'(rpt_prog), NP - 1);
    endtask

    initial begin
        int guard;
        reset = 1'b1; go = 1'b0; abort = 1'b0; core_done = 1'b0; rpt_ready = 1'b0;
        run_prog = -1; run_idx = 0; hi_cnt = 0; stall_left = 0; n_acc = 0;
        busy_cnt = 0; exp_busy = 0; prev_low = 1'b0; prev_valid = 1'b0; acc_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        step();
        step();
        chk("idle_without_go", 32'(busy), 0);

        // Three normal programs, then timeout on program 1, then stalled host
        start_seq(5, 5, 5, 0, 0, 0);
        finish_seq();
        start_seq(5, NEVER, 4, 0, 0, 0);
        finish_seq();
        start_seq(3, 2, 6, 0, 7, 0);
        finish_seq();

        // done on the watchdog cycle, and a run that lasts exactly TIMEOUT
        start_seq(TO - 1, TO - 1, TO, 0, 1, 0);
        finish_seq();

        // Randomized delays (including zero and beyond the watchdog) and host stalls
        repeat (6) begin
            start_seq($urandom_range(0, TO + 3), $urandom_range(0, TO + 3), $urandom_range(0, TO + 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            finish_seq();
        end

        // Abort in the middle of program 1's run
        start_seq(3, NEVER, 3, 0, 0, 0);
        guard = 0;
        while (!(run_prog == 1 && !core_start && run_idx >= 4) && guard < 200) begin
            step();
            guard++;
        end
        chk("abort_point_reached", 32'(guard < 200), 1);
        abort = 1'b1;
        go    = 1'b0;
        step();
        abort = 1'b0;
        check_reset_vals();
        exp_q.delete();
        step();
        chk("idle_after_abort", 32'(busy), 0);
        start_seq(1, 2, 3, 0, 0, 0);
        finish_seq();

        // Reset while a report is waiting on the host
        start_seq(2, 2, 2, 0, 50, 0);
        guard = 0;
        while (!(rpt_valid && n_acc == 1 && stall_left < 45) && guard < 300) begin
            step();
            guard++;
        end
        chk("reset_point_reached", 32'(guard < 300), 1);
        reset = 1'b1;
        go    = 1'b0;
        step();
        reset = 1'b0;
        check_reset_vals();
        exp_q.delete();
        step();
        chk("idle_after_reset", 32'(busy), 0);
        start_seq(4, 0, 7, 1, 0, 2);
        finish_seq();
        start_seq(6, 6, 6, 0, 0, 0);
        finish_seq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
